// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: fetch-stage PC sequencer with an internal return-address stack and run/halt/fault FSM.
// Optional build macro RAS_WRAP_EN: circular RAS that overwrites the oldest entry on overflow instead of faulting.
module pc_flow_ctrl #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 8,
    parameter int START_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stall,
    input  logic                               halt_instr,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               jump,
    input  logic                               branch_taken,
    input  logic [D-1:0]                       target,
    output logic [D-1:0]                       pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   ras_depth,
    output logic                               running,
    output logic                               done,
    output logic                               fault
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(STACK_DEPTH - 1);
    localparam logic [D-1:0]  START_PC   = D'(START_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_FAULT} state_t;

    state_t         state_reg;
    logic [D-1:0]   pc_reg;
    logic [DW-1:0]  depth_reg;
    logic [PW-1:0]  ptr_reg;
    logic           running_reg;
    logic           done_reg;
    logic           fault_reg;

    logic [D-1:0]   ras_mem [STACK_DEPTH];

    logic [D-1:0]   pc_plus1;
    logic [D-1:0]   ras_top;
    logic [PW-1:0]  ptr_inc;
    logic [PW-1:0]  ptr_dec;
    logic           do_call;
    logic           ras_full;
    logic           push_en;
    logic [DW-1:0]  depth_after_push;

    // ptr_reg is the next write slot; it wraps so the same pointer serves the circular variant.
    assign pc_plus1 = pc_reg + D'(1);
    assign ptr_inc  = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + PW'(1);
    assign ptr_dec  = (ptr_reg == '0) ? PTR_LAST : ptr_reg - PW'(1);
    assign ras_top  = ras_mem[ptr_dec];
    assign ras_full = (depth_reg == DEPTH_FULL);
    assign do_call  = (state_reg == S_RUN) && !stall && !halt_instr && !ret && call;

`ifdef RAS_WRAP_EN
    assign push_en          = do_call;
    assign depth_after_push = ras_full ? depth_reg : depth_reg + DW'(1);
`else
    assign push_en          = do_call && !ras_full;
    assign depth_after_push = depth_reg + DW'(1);
`endif

    // Return-address storage carries no reset; contents are meaningless while depth is 0.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[ptr_reg] <= pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= START_PC;
            depth_reg   <= '0;
            ptr_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (!stall) begin
                        if (halt_instr) begin
                            state_reg   <= S_HALTED;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else if (ret) begin
                            if (depth_reg == '0) begin
                                state_reg   <= S_FAULT;
                                running_reg <= 1'b0;
                                fault_reg   <= 1'b1;
                            end else begin
                                pc_reg    <= ras_top;
                                depth_reg <= depth_reg - DW'(1);
                                ptr_reg   <= ptr_dec;
                            end
                        end else if (call) begin
                            if (push_en) begin
                                pc_reg    <= target;
                                depth_reg <= depth_after_push;
                                ptr_reg   <= ptr_inc;
                            end else begin
                                state_reg   <= S_FAULT;
                                running_reg <= 1'b0;
                                fault_reg   <= 1'b1;
                            end
                        end else if (jump || branch_taken) begin
                            pc_reg <= target;
                        end else begin
                            pc_reg <= pc_plus1;
                        end
                    end
                end
                default: begin
                    // IDLE, HALTED and FAULT all restart cleanly on start.
                    if (start) begin
                        state_reg   <= S_RUN;
                        pc_reg      <= START_PC;
                        depth_reg   <= '0;
                        ptr_reg     <= '0;
                        running_reg <= 1'b1;
                        done_reg    <= 1'b0;
                        fault_reg   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pc        = pc_reg;
    assign ras_depth = depth_reg;
    assign running   = running_reg;
    assign done      = done_reg;
    assign fault     = fault_reg;
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_pc_flow_ctrl;
    localparam int D     = 12;
    localparam int SD    = 8;
    localparam int START = 0;
    localparam int DW    = $clog2(SD + 1);
    localparam int PCMOD = 1 << D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, stall = 1'b0, halt_instr = 1'b0, call = 1'b0;
    logic          ret = 1'b0, jump = 1'b0, branch_taken = 1'b0;
    logic [D-1:0]  target = '0;
    logic [D-1:0]  pc;
    logic [DW-1:0] ras_depth;
    logic          running, done, fault;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {M_IDLE, M_RUN, M_HALTED, M_FAULT} mstate_t;
    mstate_t m_state;
    int      m_pc;
    int      m_ras[$];

    always #5 clk = ~clk;

    pc_flow_ctrl #(.D(D), .STACK_DEPTH(SD), .START_ADDR(START)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_instr(halt_instr),
        .call(call), .ret(ret), .jump(jump), .branch_taken(branch_taken), .target(target),
        .pc(pc), .ras_depth(ras_depth), .running(running), .done(done), .fault(fault)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = START;
        m_ras.delete();
    endtask

    // Reference: the stack is a plain queue, highest-priority request decides the cycle.
    task automatic model_step();
        if (m_state != M_RUN) begin
            if (start) begin
                m_state = M_RUN;
                m_pc    = START;
                m_ras.delete();
            end
        end else if (stall) begin
        end else if (halt_instr) begin
            m_state = M_HALTED;
        end else if (ret) begin
            if (m_ras.size() == 0) m_state = M_FAULT;
            else m_pc = m_ras.pop_back();
        end else if (call) begin
            if (m_ras.size() == SD) begin
`ifdef RAS_WRAP_EN
                void'(m_ras.pop_front());
                m_ras.push_back((m_pc + 1) % PCMOD);
                m_pc = int'(target);
`else
                m_state = M_FAULT;
`endif
            end else begin
                m_ras.push_back((m_pc + 1) % PCMOD);
                m_pc = int'(target);
            end
        end else if (jump || branch_taken) begin
            m_pc = int'(target);
        end else begin
            m_pc = (m_pc + 1) % PCMOD;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("pc", int'(pc), m_pc);
            check("depth", int'(ras_depth), m_ras.size());
            check("running", int'(running), int'(m_state == M_RUN));
            check("done", int'(done), int'(m_state == M_HALTED));
            check("fault", int'(fault), int'(m_state == M_FAULT));
        end
    end

    task automatic clr();
        start = 0; stall = 0; halt_instr = 0; call = 0; ret = 0; jump = 0; branch_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check("rst_pc", int'(pc), 0);
        check("rst_depth", int'(ras_depth), 0);
        check("rst_running", int'(running), 0);

        // 1: start and sequential fetch
        start = 1; tick(); clr();
        check("t1_pc0", int'(pc), 0);
        check("t1_running", int'(running), 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t1_pc", int'(pc), i);
        end
        check("t1_depth", int'(ras_depth), 0);

        // 2: call / ret
        tick();
        check("t2_pc5", int'(pc), 5);
        call = 1; target = 12'h040; tick(); clr();
        check("t2_call_pc", int'(pc), 'h040);
        check("t2_call_depth", int'(ras_depth), 1);
        tick(); tick();
        check("t2_pc42", int'(pc), 'h042);
        ret = 1; tick(); clr();
        check("t2_ret_pc", int'(pc), 'h006);
        check("t2_ret_depth", int'(ras_depth), 0);

        // 3: nested calls and overflow
        for (int k = 1; k <= 8; k++) begin
            call = 1; target = D'(32'h100 + k * 16); tick();
        end
        clr();
        check("t3_depth8", int'(ras_depth), 8);
        check("t3_pc8", int'(pc), 'h180);
        call = 1; target = 12'h300; tick(); clr();
`ifdef RAS_WRAP_EN
        check("t3_wrap_fault", int'(fault), 0);
        check("t3_wrap_depth", int'(ras_depth), 8);
        check("t3_wrap_pc", int'(pc), 'h300);
        for (int k = 8; k >= 1; k--) begin
            ret = 1; tick();
            check("t3_wrap_ret", int'(pc), 'h100 + k * 16 + 1);
        end
        ret = 1; tick(); clr();
        check("t3_wrap_underflow", int'(fault), 1);
`else
        check("t3_ovf_fault", int'(fault), 1);
        check("t3_ovf_pc", int'(pc), 'h180);
        check("t3_ovf_depth", int'(ras_depth), 8);
`endif

        // 4: underflow fault and restart
        start = 1; tick(); clr();
        ret = 1; tick(); clr();
        check("t4_fault", int'(fault), 1);
        check("t4_pc_hold", int'(pc), 0);
        start = 1; tick(); clr();
        check("t4_restart_pc", int'(pc), 0);
        check("t4_restart_depth", int'(ras_depth), 0);
        check("t4_restart_run", int'(running), 1);

        // 5: stall dominates, ret beats call
        call = 1; target = 12'h020; tick(); clr();
        stall = 1; call = 1; target = 12'h100; tick(); clr();
        check("t5_stall_pc", int'(pc), 'h020);
        check("t5_stall_depth", int'(ras_depth), 1);
        call = 1; ret = 1; target = 12'h200; tick(); clr();
        check("t5_retwins_pc", int'(pc), 1);
        check("t5_retwins_depth", int'(ras_depth), 0);

        // 6: wrap, call at top of address space, halt, async reset
        jump = 1; target = 12'hFFF; tick(); clr();
        tick();
        check("t6_wrap", int'(pc), 0);
        jump = 1; target = 12'hFFF; tick(); clr();
        call = 1; target = 12'h010; tick(); clr();
        ret = 1; tick(); clr();
        check("t6_ret_wrap", int'(pc), 0);
        jump = 1; target = 12'h0AB; tick(); clr();
        halt_instr = 1; tick(); clr();
        check("t6_done", int'(done), 1);
        check("t6_halt_pc", int'(pc), 'h0AB);
        jump = 1; target = 12'h333; tick(); clr();
        check("t6_halted_ignore", int'(pc), 'h0AB);
        #1 reset = 1'b1;
        #1;
        check("t6_async_pc", int'(pc), START);
        check("t6_async_done", int'(done), 0);
        #2 reset = 1'b0;

        // randomized traffic
        tick();
        start = 1; tick(); clr();
        for (int c = 0; c < 4000; c++) begin
            start        = ($urandom_range(0, 99) < 5);
            stall        = ($urandom_range(0, 99) < 10);
            halt_instr   = ($urandom_range(0, 99) < 2);
            ret          = ($urandom_range(0, 99) < 20);
            call         = ($urandom_range(0, 99) < 26);
            jump         = ($urandom_range(0, 99) < 10);
            branch_taken = ($urandom_range(0, 99) < 10);
            target       = D'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            tick();
        end
        clr();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
